// File: rtl/rf80386_dbiu_if.sv
// fta bus master-side signal bundle used between rf80386_dbiu and the bus fabric.
interface rf80386_dbiu_if #(
  parameter int BUS_BYTES = 16,
  parameter int TID_BITS  = 4
);
  logic                   bus_cyc_o;
  logic                   bus_stb_o;
  logic                   bus_we_o;
  logic [31:0]            bus_adr_o;
  logic [BUS_BYTES-1:0]   bus_sel_o;
  logic [BUS_BYTES*8-1:0] bus_dat_o;
  logic [TID_BITS-1:0]    bus_tid_o;
  logic [5:0]             bus_core_o;
  logic [2:0]             bus_chan_o;
  logic                   bus_ack_i;
  logic                   bus_rty_i;
  logic                   bus_err_i;
  logic [TID_BITS-1:0]    bus_tid_i;
  logic [BUS_BYTES*8-1:0] bus_dat_i;

  modport master (
    output bus_cyc_o, bus_stb_o, bus_we_o, bus_adr_o, bus_sel_o, bus_dat_o,
           bus_tid_o, bus_core_o, bus_chan_o,
    input  bus_ack_i, bus_rty_i, bus_err_i, bus_tid_i, bus_dat_i
  );

  modport slave (
    input  bus_cyc_o, bus_stb_o, bus_we_o, bus_adr_o, bus_sel_o, bus_dat_o,
           bus_tid_o, bus_core_o, bus_chan_o,
    output bus_ack_i, bus_rty_i, bus_err_i, bus_tid_i, bus_dat_i
  );
endinterface

// File: rtl/rf80386_dbiu.sv
// Data bus interface unit: maps 1..8 byte load/store operands onto fta-bus line
// transactions, splitting line-crossing accesses, with tid tracking, retry and timeout.
module rf80386_dbiu #(
  parameter int BUS_BYTES = 16,
  parameter int MAX_BYTES = 4,
  parameter int TID_BITS  = 4,
  parameter int RTY_WAIT  = 16,
  parameter int TIMEOUT   = 1023,
  parameter int CORENO    = 1,
  parameter int CID       = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  output logic                   rdy_o,
  input  logic                   we_i,
  input  logic [31:0]            adr_i,
  input  logic [1:0]             size_i,
  input  logic [MAX_BYTES*8-1:0] wdat_i,
  output logic                   done_o,
  output logic                   err_o,
  output logic [MAX_BYTES*8-1:0] rdat_o,
  output logic                   split_o,
  rf80386_dbiu_if.master         bus
);

  localparam int OFFW = $clog2(BUS_BYTES);
  localparam int LW   = BUS_BYTES * 8;
  localparam int DW   = 2 * LW;
  localparam int MW   = 2 * BUS_BYTES;
  localparam int RW   = MAX_BYTES * 8;
  localparam int MAXC = (TIMEOUT > RTY_WAIT) ? TIMEOUT : RTY_WAIT;
  localparam int CNTW = $clog2(MAXC + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RTYW, DONE} state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [31:0]         adr_q, adr_d;
  logic [1:0]          size_q, size_d;
  logic [RW-1:0]       wdat_q, wdat_d;
  logic                part_q, part_d;
  logic [TID_BITS-1:0] tid_q, tid_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [DW-1:0]       asm_q, asm_d;
  logic [RW-1:0]       rdat_q, rdat_d;

  logic [OFFW-1:0]     off;
  logic [3:0]          nBytes;
  logic                split;
  logic [31:0]         lineAdr;
  logic [MW-1:0]       laneMask;
  logic [DW-1:0]       laneDat;
  logic [RW-1:0]       byteMask;
  logic [DW-1:0]       asmShift;
  logic [TID_BITS-1:0] tidInc;
  logic                hit;
  logic                active;

  // Both parts are cut from one double-line window so part1 is simply its upper half.
  always_comb begin
    off      = adr_q[OFFW-1:0];
    nBytes   = 4'd1 << size_q;
    split    = (8'(off) + 8'(nBytes)) > 8'(BUS_BYTES);
    lineAdr  = {adr_q[31:OFFW], {OFFW{1'b0}}};
    laneMask = ((MW'(1) << nBytes) - MW'(1)) << off;
    laneDat  = DW'(wdat_q) << {off, 3'b000};
    for (int b = 0; b < MAX_BYTES; b++) begin
      byteMask[b*8 +: 8] = (b < int'(nBytes)) ? 8'hFF : 8'h00;
    end
    tidInc = (tid_q == {TID_BITS{1'b1}}) ? TID_BITS'(1) : tid_q + TID_BITS'(1);
    hit    = (bus.bus_tid_i == tid_q);
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    adr_d    = adr_q;
    size_d   = size_q;
    wdat_d   = wdat_q;
    part_d   = part_q;
    tid_d    = tid_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    asm_d    = asm_q;
    rdat_d   = rdat_q;
    asmShift = '0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          adr_d   = adr_i;
          size_d  = size_i;
          wdat_d  = wdat_i;
          part_d  = 1'b0;
          err_d   = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (hit && bus.bus_err_i) begin
          err_d   = 1'b1;
          state_d = DONE;
          if (!we_q) rdat_d = '0;
        end else if (hit && bus.bus_rty_i) begin
          cnt_d   = CNTW'(RTY_WAIT);
          state_d = RTYW;
        end else if (hit && bus.bus_ack_i) begin
          if (!we_q) begin
            if (part_q) asm_d[DW-1:LW] = bus.bus_dat_i;
            else        asm_d[LW-1:0]  = bus.bus_dat_i;
          end
          if (split && !part_q) begin
            part_d  = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = DONE;
            if (!we_q) begin
              asmShift = asm_d >> {off, 3'b000};
              rdat_d   = byteMask & asmShift[RW-1:0];
            end
          end
        end else if (cnt_q == CNTW'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = DONE;
          if (!we_q) rdat_d = '0;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      RTYW: begin
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q <= CNTW'(1)) state_d = ISSUE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Every issue takes a fresh tid and restarts the response timeout.
    if (state_d == ISSUE) begin
      tid_d = tidInc;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      adr_q   <= '0;
      size_q  <= '0;
      wdat_q  <= '0;
      part_q  <= 1'b0;
      tid_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      asm_q   <= '0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      size_q  <= size_d;
      wdat_q  <= wdat_d;
      part_q  <= part_d;
      tid_q   <= tid_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      asm_q   <= asm_d;
      rdat_q  <= rdat_d;
    end
  end

  assign active         = (state_q == ISSUE) || (state_q == WAIT);
  assign rdy_o          = (state_q == IDLE);
  assign done_o         = (state_q == DONE);
  assign err_o          = done_o & err_q;
  assign split_o        = done_o & split;
  assign rdat_o         = rdat_q;
  assign bus.bus_cyc_o  = active;
  assign bus.bus_stb_o  = active;
  assign bus.bus_we_o   = active & we_q;
  assign bus.bus_adr_o  = active ? (part_q ? lineAdr + 32'(BUS_BYTES) : lineAdr) : '0;
  assign bus.bus_sel_o  = active ? (part_q ? laneMask[MW-1:BUS_BYTES] : laneMask[BUS_BYTES-1:0]) : '0;
  assign bus.bus_dat_o  = active ? (part_q ? laneDat[DW-1:LW] : laneDat[LW-1:0]) : '0;
  assign bus.bus_tid_o  = tid_q;
  assign bus.bus_core_o = 6'(CORENO);
  assign bus.bus_chan_o = 3'(CID);

endmodule

// File: tb/tb_rf80386_dbiu.sv
// Directed bench for rf80386_dbiu with BUS_BYTES=16; the bench plays the bus slave by hand.
module tb_rf80386_dbiu;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i  = 1'b0;
  logic [31:0] adr_i = '0;
  logic [1:0]  size_i = '0;
  logic [31:0] wdat_i = '0;
  logic        rdy_o, done_o, err_o, split_o;
  logic [31:0] rdat_o;
  int          total = 0;
  int          bad = 0;

  rf80386_dbiu_if #(.BUS_BYTES(16), .TID_BITS(4)) bus ();

  rf80386_dbiu #(
    .BUS_BYTES(16), .MAX_BYTES(4), .TID_BITS(4), .RTY_WAIT(16),
    .TIMEOUT(1023), .CORENO(1), .CID(1)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .rdy_o(rdy_o), .we_i(we_i),
    .adr_i(adr_i), .size_i(size_i), .wdat_i(wdat_i), .done_o(done_o),
    .err_o(err_o), .rdat_o(rdat_o), .split_o(split_o), .bus(bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic startReq(input logic we, input logic [31:0] adr, input logic [1:0] sz,
                          input logic [31:0] wd);
    req_i = 1'b1; we_i = we; adr_i = adr; size_i = sz; wdat_i = wd;
    tick();
    req_i = 1'b0;
  endtask

  task automatic respond(input logic a, input logic r, input logic e, input logic [3:0] t,
                         input logic [127:0] d);
    bus.bus_ack_i = a; bus.bus_rty_i = r; bus.bus_err_i = e;
    bus.bus_tid_i = t; bus.bus_dat_i = d;
    tick();
    bus.bus_ack_i = 1'b0; bus.bus_rty_i = 1'b0; bus.bus_err_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b0;
    tick(); tick();
    total++; if (rdy_o !== 1'b1) begin bad++; $display("[TB] FAIL reset_rdy got %b want 1", rdy_o); end
    total++; if ({done_o, err_o, split_o} !== 3'b000) begin bad++; $display("[TB] FAIL reset_flags got %b want 000", {done_o, err_o, split_o}); end
    total++; if ({bus.bus_cyc_o, bus.bus_stb_o, bus.bus_we_o} !== 3'b000) begin bad++; $display("[TB] FAIL reset_ctl got %b want 000", {bus.bus_cyc_o, bus.bus_stb_o, bus.bus_we_o}); end
    total++; if (bus.bus_adr_o !== 32'h0 || bus.bus_sel_o !== 16'h0 || bus.bus_dat_o !== 128'h0) begin bad++; $display("[TB] FAIL reset_bus adr %h sel %h want 0", bus.bus_adr_o, bus.bus_sel_o); end
    total++; if (rdat_o !== 32'h0) begin bad++; $display("[TB] FAIL reset_rdat got %h want 0", rdat_o); end
    total++; if (bus.bus_core_o !== 6'd1 || bus.bus_chan_o !== 3'd1) begin bad++; $display("[TB] FAIL core_chan got %0d/%0d want 1/1", bus.bus_core_o, bus.bus_chan_o); end
    rst_i = 1'b1;
    tick();
  endtask

  task automatic test_load;
    total++; if (rdy_o !== 1'b1) begin bad++; $display("[TB] FAIL load_rdy0 got %b want 1", rdy_o); end
    startReq(1'b0, 32'h1004, 2'd2, 32'h0);
    total++; if (bus.bus_stb_o !== 1'b1 || rdy_o !== 1'b0) begin bad++; $display("[TB] FAIL load_stb1 stb %b rdy %b want 1/0", bus.bus_stb_o, rdy_o); end
    total++; if (bus.bus_adr_o !== 32'h1000) begin bad++; $display("[TB] FAIL load_adr got %h want 00001000", bus.bus_adr_o); end
    total++; if (bus.bus_sel_o !== 16'h00F0) begin bad++; $display("[TB] FAIL load_sel got %h want 00f0", bus.bus_sel_o); end
    total++; if (bus.bus_tid_o !== 4'd1 || bus.bus_we_o !== 1'b0) begin bad++; $display("[TB] FAIL load_tid got %0d we %b want 1/0", bus.bus_tid_o, bus.bus_we_o); end
    tick();
    total++; if (bus.bus_stb_o !== 1'b1 || done_o !== 1'b0) begin bad++; $display("[TB] FAIL load_wait stb %b done %b want 1/0", bus.bus_stb_o, done_o); end
    respond(1'b1, 1'b0, 1'b0, 4'd1, {64'h1122334455667788, 32'hDDCCBBAA, 32'h99999999});
    total++; if (done_o !== 1'b1 || err_o !== 1'b0 || split_o !== 1'b0) begin bad++; $display("[TB] FAIL load_done d/e/s %b%b%b want 100", done_o, err_o, split_o); end
    total++; if (rdat_o !== 32'hDDCCBBAA) begin bad++; $display("[TB] FAIL load_rdat got %h want ddccbbaa", rdat_o); end
    total++; if (bus.bus_stb_o !== 1'b0) begin bad++; $display("[TB] FAIL load_stbdrop got %b want 0", bus.bus_stb_o); end
    tick();
    total++; if (done_o !== 1'b0 || rdy_o !== 1'b1) begin bad++; $display("[TB] FAIL load_idle done %b rdy %b want 0/1", done_o, rdy_o); end
  endtask

  task automatic test_split_store;
    startReq(1'b1, 32'h100E, 2'd2, 32'h44332211);
    total++; if (bus.bus_adr_o !== 32'h1000 || bus.bus_sel_o !== 16'hC000) begin bad++; $display("[TB] FAIL st_p0 adr %h sel %h want 00001000/c000", bus.bus_adr_o, bus.bus_sel_o); end
    total++; if (bus.bus_dat_o !== {16'h2211, 112'h0}) begin bad++; $display("[TB] FAIL st_p0_dat got %h", bus.bus_dat_o); end
    total++; if (bus.bus_tid_o !== 4'd2 || bus.bus_we_o !== 1'b1) begin bad++; $display("[TB] FAIL st_p0_tid got %0d we %b want 2/1", bus.bus_tid_o, bus.bus_we_o); end
    tick();
    respond(1'b1, 1'b0, 1'b0, 4'd2, 128'h0);
    total++; if (bus.bus_adr_o !== 32'h1010 || bus.bus_sel_o !== 16'h0003) begin bad++; $display("[TB] FAIL st_p1 adr %h sel %h want 00001010/0003", bus.bus_adr_o, bus.bus_sel_o); end
    total++; if (bus.bus_dat_o !== {112'h0, 16'h4433}) begin bad++; $display("[TB] FAIL st_p1_dat got %h", bus.bus_dat_o); end
    total++; if (bus.bus_tid_o !== 4'd3 || bus.bus_stb_o !== 1'b1) begin bad++; $display("[TB] FAIL st_p1_tid got %0d stb %b want 3/1", bus.bus_tid_o, bus.bus_stb_o); end
    tick();
    respond(1'b1, 1'b0, 1'b0, 4'd3, 128'h0);
    total++; if (done_o !== 1'b1 || split_o !== 1'b1 || err_o !== 1'b0) begin bad++; $display("[TB] FAIL st_done d/s/e %b%b%b want 110", done_o, split_o, err_o); end
    total++; if (rdat_o !== 32'hDDCCBBAA) begin bad++; $display("[TB] FAIL st_rdat_kept got %h want ddccbbaa", rdat_o); end
    tick();
  endtask

  task automatic test_retry;
    int idle;
    startReq(1'b0, 32'h2008, 2'd2, 32'h0);
    total++; if (bus.bus_tid_o !== 4'd4) begin bad++; $display("[TB] FAIL rty_tid0 got %0d want 4", bus.bus_tid_o); end
    tick();
    respond(1'b0, 1'b1, 1'b0, 4'd4, 128'h0);
    idle = 0;
    while (bus.bus_stb_o !== 1'b1 && idle < 100) begin
      idle++;
      tick();
    end
    total++; if (idle != 16) begin bad++; $display("[TB] FAIL rty_idle got %0d want 16", idle); end
    total++; if (bus.bus_tid_o !== 4'd5 || bus.bus_adr_o !== 32'h2000 || bus.bus_sel_o !== 16'h0F00) begin bad++; $display("[TB] FAIL rty_reissue tid %0d adr %h sel %h want 5/00002000/0f00", bus.bus_tid_o, bus.bus_adr_o, bus.bus_sel_o); end
    tick();
    respond(1'b1, 1'b0, 1'b0, 4'd5, {32'h0, 32'h87654321, 64'h0});
    total++; if (done_o !== 1'b1 || err_o !== 1'b0 || rdat_o !== 32'h87654321) begin bad++; $display("[TB] FAIL rty_done d %b e %b rdat %h want 1/0/87654321", done_o, err_o, rdat_o); end
    tick();
  endtask

  task automatic test_wrong_tid;
    startReq(1'b0, 32'h3000, 2'd0, 32'h0);
    tick();
    respond(1'b1, 1'b0, 1'b0, 4'd7, {{15{8'hFF}}, 8'h77});
    total++; if (done_o !== 1'b0 || bus.bus_stb_o !== 1'b1) begin bad++; $display("[TB] FAIL wtid_ignored done %b stb %b want 0/1", done_o, bus.bus_stb_o); end
    tick();
    total++; if (done_o !== 1'b0) begin bad++; $display("[TB] FAIL wtid_nodone got %b want 0", done_o); end
    respond(1'b1, 1'b0, 1'b0, 4'd6, {{15{8'hFF}}, 8'h5A});
    total++; if (done_o !== 1'b1 || rdat_o !== 32'h0000005A) begin bad++; $display("[TB] FAIL wtid_done d %b rdat %h want 1/0000005a", done_o, rdat_o); end
    tick();
  endtask

  task automatic test_split_load;
    startReq(1'b0, 32'h60FE, 2'd2, 32'h0);
    total++; if (bus.bus_adr_o !== 32'h60F0 || bus.bus_sel_o !== 16'hC000 || bus.bus_tid_o !== 4'd7) begin bad++; $display("[TB] FAIL ld_p0 adr %h sel %h tid %0d want 000060f0/c000/7", bus.bus_adr_o, bus.bus_sel_o, bus.bus_tid_o); end
    tick();
    respond(1'b1, 1'b0, 1'b0, 4'd7, {16'h2211, {14{8'hEE}}});
    total++; if (bus.bus_adr_o !== 32'h6100 || bus.bus_tid_o !== 4'd8) begin bad++; $display("[TB] FAIL ld_p1 adr %h tid %0d want 00006100/8", bus.bus_adr_o, bus.bus_tid_o); end
    tick();
    respond(1'b1, 1'b0, 1'b0, 4'd8, {{14{8'hEE}}, 16'h4433});
    total++; if (done_o !== 1'b1 || split_o !== 1'b1 || err_o !== 1'b0) begin bad++; $display("[TB] FAIL ld_done d/s/e %b%b%b want 110", done_o, split_o, err_o); end
    total++; if (rdat_o !== 32'h44332211) begin bad++; $display("[TB] FAIL ld_rdat got %h want 44332211", rdat_o); end
    tick();
  endtask

  task automatic test_timeout;
    int n;
    startReq(1'b0, 32'h4000, 2'd2, 32'h0);
    n = 1;
    while (done_o !== 1'b1 && n < 1200) begin
      tick();
      n++;
    end
    total++; if (done_o !== 1'b1 || n < 1020 || n > 1032) begin bad++; $display("[TB] FAIL tmo_latency done %b at cycle %0d want 1 near 1026", done_o, n); end
    total++; if (err_o !== 1'b1 || rdat_o !== 32'h0) begin bad++; $display("[TB] FAIL tmo_err e %b rdat %h want 1/00000000", err_o, rdat_o); end
    tick();
  endtask

  task automatic test_split_err;
    startReq(1'b0, 32'h70FE, 2'd2, 32'h0);
    tick();
    respond(1'b1, 1'b0, 1'b0, 4'd10, 128'h0);
    total++; if (bus.bus_tid_o !== 4'd11 || bus.bus_adr_o !== 32'h7100) begin bad++; $display("[TB] FAIL serr_p1 tid %0d adr %h want 11/00007100", bus.bus_tid_o, bus.bus_adr_o); end
    tick();
    respond(1'b0, 1'b0, 1'b1, 4'd11, 128'h0);
    total++; if (done_o !== 1'b1 || err_o !== 1'b1) begin bad++; $display("[TB] FAIL serr_done d %b e %b want 1/1", done_o, err_o); end
    tick();
  endtask

  task automatic test_tid_wrap;
    logic [3:0] exp;
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      exp = 4'((i % 15) + 1);
      startReq(1'b0, 32'h8000, 2'd2, 32'h0);
      total++; if (bus.bus_tid_o !== exp) begin bad++; $display("[TB] FAIL wrap_tid[%0d] got %0d want %0d", i, bus.bus_tid_o, exp); end
      tick();
      respond(1'b1, 1'b0, 1'b0, exp, {96'h0, 32'hA5A5A5A5});
      total++; if (done_o !== 1'b1) begin bad++; $display("[TB] FAIL wrap_done[%0d] got %b want 1", i, done_o); end
      tick();
    end
  endtask

  task automatic test_reset_mid;
    startReq(1'b0, 32'h9000, 2'd2, 32'h0);
    tick();
    rst_i = 1'b0;
    tick();
    total++; if (rdy_o !== 1'b1 || done_o !== 1'b0) begin bad++; $display("[TB] FAIL rmid_state rdy %b done %b want 1/0", rdy_o, done_o); end
    total++; if (bus.bus_cyc_o !== 1'b0 || bus.bus_stb_o !== 1'b0 || bus.bus_adr_o !== 32'h0 || bus.bus_sel_o !== 16'h0) begin bad++; $display("[TB] FAIL rmid_bus cyc %b adr %h sel %h want 0", bus.bus_cyc_o, bus.bus_adr_o, bus.bus_sel_o); end
    total++; if (rdat_o !== 32'h0) begin bad++; $display("[TB] FAIL rmid_rdat got %h want 0", rdat_o); end
    rst_i = 1'b1;
    respond(1'b1, 1'b0, 1'b0, 4'd2, {96'h0, 32'h12345678});
    for (int k = 0; k < 3; k++) begin
      total++; if (done_o !== 1'b0 || rdy_o !== 1'b1) begin bad++; $display("[TB] FAIL rmid_late[%0d] done %b rdy %b want 0/1", k, done_o, rdy_o); end
      tick();
    end
  endtask

  initial begin
    bus.bus_ack_i = 1'b0;
    bus.bus_rty_i = 1'b0;
    bus.bus_err_i = 1'b0;
    bus.bus_tid_i = '0;
    bus.bus_dat_i = '0;
    test_reset();
    test_load();
    test_split_store();
    test_retry();
    test_wrong_tid();
    test_split_load();
    test_timeout();
    test_split_err();
    test_tid_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf80386_dbiu.md
Name: rf80386_dbiu

Overview:
Parametrised data bus interface unit for the rf80386 core. It turns single-operand load/store requests of 1, 2 or 4 bytes (8 with MAX_BYTES=8) into fta-bus line transactions. It places bytes into line lanes and generates byte selects. Accesses that cross a line boundary are split into two transactions. It also manages transaction IDs, retry back-off and timeout, and sits between the execute/loadstore states and the fta bus master port.

Parameters:
BUS_BYTES, 16, bus line width in bytes (power of 2, 4..32)
MAX_BYTES, 4, largest operand in bytes (4 or 8)
TID_BITS, 4, transaction-id width
RTY_WAIT, 16, idle cycles after a retry response before reissue (>=1)
TIMEOUT, 1023, cycles waiting for a response before an error completion
CORENO, 1, core number driven on bus_core_o
CID, 1, channel id driven on bus_chan_o

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-low reset
req_i  in  1  access request, valid when rdy_o=1
rdy_o  out  1  unit idle, can accept req_i
we_i  in  1  1=store, 0=load
adr_i  in  32  linear byte address
size_i  in  2  0=1B, 1=2B, 2=4B, 3=8B (3 only legal if MAX_BYTES=8)
wdat_i  in  MAX_BYTES*8  store data, LSB at adr_i
done_o  out  1  one-cycle completion pulse
err_o  out  1  valid with done_o: bus error or timeout
rdat_o  out  MAX_BYTES*8  load data, zero-extended, held until next done_o
split_o  out  1  valid with done_o: access used two transactions
bus_cyc_o, bus_stb_o, bus_we_o  out  1 each  fta bus controls
bus_adr_o  out  32  line-aligned address
bus_sel_o  out  BUS_BYTES  byte lane selects
bus_dat_o  out  BUS_BYTES*8  store data in lanes
bus_tid_o  out  TID_BITS  transaction id
bus_core_o  out  6  CORENO
bus_chan_o  out  3  CID
bus_ack_i, bus_rty_i, bus_err_i  in  1 each  response strobes
bus_tid_i  in  TID_BITS  response id
bus_dat_i  in  BUS_BYTES*8  response data

Behaviour:
- Reset (rst_i=0 at a clk_i edge): state IDLE; rdy_o=1; done_o, err_o, split_o, bus_cyc_o, bus_stb_o, bus_we_o=0; bus_sel_o, bus_adr_o, bus_dat_o, rdat_o=0; tid counter=0. Reset mid-transaction abandons it with no done_o. Late responses after reset are ignored, because their ids never match until the counter re-reaches them through a fresh issue.
- States: IDLE, ISSUE, WAIT, RTYW, DONE.
- IDLE: req_i=1 latches all request inputs, rdy_o->0, goes to ISSUE. The request is latched in cycle 0 and the bus is driven in cycle 1.
- Split rule: off=adr[log2 BUS_BYTES-1:0], n=1<<size. If off+n>BUS_BYTES, part0 covers lanes off..BUS_BYTES-1 and part1 covers lanes 0..off+n-BUS_BYTES-1 at line address +BUS_BYTES, with 32-bit wrap allowed. Otherwise there is one part.
- ISSUE (one cycle): tid=tid+1. The tid wraps from 2^TID_BITS-1 to 1 and is never 0. Drive cyc/stb/we/adr/sel/dat for the current part, then go to WAIT.
- WAIT: bus outputs are held stable. A response counts only if bus_tid_i equals the issued tid. Other ids are ignored.
  - Matching ack: on a load, capture that part's lanes into the assembly register. Then drop cyc/stb; go to ISSUE for part1 or to DONE.
  - Matching rty: drop cyc/stb, load the wait counter with RTY_WAIT, go to RTYW.
  - Matching err: set the error flag and go to DONE with no further parts.
  - Simultaneous matching strobes: priority is err > rty > ack.
  - Timeout counter reaches TIMEOUT with no matching response: error, go to DONE.
- RTYW: bus idle, counter decrements. At 0 go to ISSUE for the same part with a new tid. The timeout counter restarts on every issue.
- DONE (one cycle): done_o=1. err_o=1 on a bus error or timeout. split_o reflects the split. Load rdat_o receives part0 data shifted down by off and part1 data placed above it, zero-extended. On error, rdat_o is 0. rdy_o returns to 1 next cycle. Stores leave rdat_o unchanged.
- Minimum latency, unsplit, ack in the first WAIT cycle: req cycle 0, stb cycles 1-2, done_o cycle 3.
- bus_core_o and bus_chan_o are constant.

Test Plan:
- BUS_BYTES=16. Load, adr=0x1004, size=2; bus_dat_i lanes 4..7 = 0xDDCCBBAA, ack with matching tid in the first WAIT cycle -> one transaction, bus_adr_o=0x1000, sel=0x00F0, tid=1; done_o at cycle 3, rdat_o=0xDDCCBBAA, split_o=0.
- Store, adr=0x100E, size=2, wdat=0x44332211 -> part0 adr=0x1000, sel=0xC000, lanes14/15=0x11/0x22; part1 adr=0x1010, sel=0x0003, lanes0/1=0x33/0x44; tids 2 then 3; split_o=1.
- Load with rty on the first response, RTY_WAIT=16 -> bus idle exactly 16 cycles, reissue with the next tid, then ack -> correct data, err_o=0.
- Ack with a wrong tid, then an ack with the correct tid two cycles later -> first ack ignored; completion follows the second ack only.
- No response, TIMEOUT=1023 -> done_o with err_o=1 and rdat_o=0. Bus err on part1 of a split load -> err_o=1.
- Issue 16 accesses -> tid sequence 1..15, then 1; never 0. Assert rst_i=0 during WAIT -> all outputs at reset values next cycle and no done_o.
